logic_analyzer_readout: RTL and testbench
=========================================

Name: logic_analyzer_readout

Overview:
- Reader side of the logic analyzer capture RAM.
- After a capture, walks RAM addresses 0..N-1 through the AI address port and fetches each 32-bit sample from DATA_OUT_RAM.
- Serializes each sample MSB-byte-first onto an 8-bit valid/ready stream that feeds the host link (UART TX or bus FIFO).
- Sits beside logic_analyzer_a_datapath. Drives its AI input and consumes its DATA_OUT_RAM and sts outputs.

Parameters:
- ADDR_W, 5: RAM address width; depth is 2**ADDR_W.
- DATA_W, 32: sample width. Must be a multiple of 8.
- BYTES, DATA_W/8: bytes per sample (localparam).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a dump. Ignored while busy.
- count  in  ADDR_W  number of captured samples (sts[ADDR_W-1:0]). Sampled on start.
- dump_all  in  1  when high at start, dump all 2**ADDR_W words and ignore count.
- DATA_OUT_RAM  in  DATA_W  RAM read data.
- AI  out  ADDR_W  RAM read address.
- busy  out  1  high from the cycle after an accepted start until done. The capture controller holds la_we low while busy.
- tx_data  out  8  byte to the host link.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  host link accepts the byte this cycle.
- done  out  1  one-cycle pulse at the end of a dump.

Behaviour:
- Reset (async): state=IDLE. AI=0, busy=0, tx_valid=0, tx_data=0, done=0. Internal word counter, byte index and shift register are cleared.
- An accepted start (state IDLE and start=1) latches the word total:
  - dump_all=1 → total = 2**ADDR_W.
  - otherwise → total = count, zero-extended to ADDR_W+1 bits.
- total=0: go directly to DONE. No bytes are sent, and done pulses on the 2nd cycle after start.
- IDLE → ADDR on an accepted start with total≠0. AI = word index (starts at 0). busy=1.
- ADDR → LATCH after 1 cycle. AI is held stable. This allows up to one cycle of RAM read latency.
- LATCH → SEND:
  - Load DATA_OUT_RAM into the shift register.
  - Byte index = 0.
  - tx_data = bits [DATA_W-1 -: 8], tx_valid=1.
- SEND:
  - tx_data and tx_valid are held stable until tx_ready=1. A registered output may not change while valid and not ready.
  - On a handshake with byte index < BYTES-1: increment the index and present the next lower byte in the following cycle. No idle bubble; tx_valid stays high.
  - On a handshake of the last byte: tx_valid=0 next cycle and go to NEXT.
- NEXT: increment the word index.
  - If word index+1 == total, go to DONE.
  - Otherwise go to ADDR with AI = the new index.
- DONE:
  - done=1 for exactly one cycle. busy falls in the same cycle as done.
  - AI returns to 0. Go to IDLE.
- Throughput with tx_ready held high: BYTES+3 cycles per word (ADDR, LATCH, BYTES×SEND, NEXT).
- Word index is ADDR_W+1 bits wide so a full 32-word dump terminates. AI is the low ADDR_W bits, and never wraps mid-dump.
- start while busy: ignored, with no effect on the counters.
- tx_ready while tx_valid=0: ignored.
- reset asserted mid-dump: immediate abort to reset values. No partial done pulse.
- count changing during a dump: no effect, because total is latched.

Decomposition:
- Shared package la_pkg holds:
  - state encoding constants (IDLE, ADDR, LATCH, SEND, NEXT, DONE);
  - LA_ADDR_W=5 and LA_DATA_W=32, also used by logic_analyzer_a_datapath and CNT5.
- One natural sub-module: la_word_serializer. It covers the shift register, the byte index and the valid/ready hold logic, with a load/word-in input and a last-byte-accepted output. The FSM and address counter stay in the top.

Test Plan:
- Preload RAM[0]=32'hDEADBEEF and RAM[1]=32'h01234567. Pulse start with count=2 and tx_ready=1 → bytes DE,AD,BE,EF,01,23,45,67 in order. AI visits 0 then 1. done pulses once, 2 cycles after the last byte handshake. busy is low afterwards.
- count=0, dump_all=0, start → no tx_valid ever. done pulses at start+2. AI stays 0.
- dump_all=1, RAM[i]={4{i[7:0]}} → 128 bytes. The last four are 1F,1F,1F,1F. AI reaches 31 and does not wrap to 0 before done.
- count=1, RAM[0]=32'hA5C3_0F81, tx_ready toggling 0,0,1,0,1,1,0,1 → each byte stays stable while not ready. The sequence is A5,C3,0F,81 with no duplicates or drops.
- Mid-dump (count=3, after the 5th byte) assert reset for 1 cycle, then pulse start with count=1 → outputs clear asynchronously with no done pulse. The new dump sends only RAM[0], then done.
- Pulse start again while busy during a count=2 dump → it is ignored: exactly 8 bytes are sent and one done pulse occurs.

Source files
------------

// File: rtl/la_pkg.sv
// Shared constants and state encoding for the logic analyzer blocks.
package la_pkg;

  localparam int LA_ADDR_W = 5;
  localparam int LA_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } la_state_e;

endpackage

// File: rtl/la_word_serializer.sv
// Splits one sample into bytes, MSB first, on a valid/ready stream.
module la_word_serializer
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_accepted
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;
  logic              handshake;

  assign handshake     = tx_valid && tx_ready;
  assign last_accepted = handshake && (byte_idx == IDX_W'(BYTES - 1));

  // shreg holds the bytes not yet presented, so tx_data only moves on a handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= word_in << 8;
      byte_idx <= '0;
      tx_data  <= word_in[DATA_W-1 -: 8];
      tx_valid <= 1'b1;
    end else if (handshake) begin
      if (last_accepted) begin
        tx_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
        tx_data  <= shreg[DATA_W-1 -: 8];
        shreg    <= shreg << 8;
      end
    end
  end

endmodule

// File: rtl/logic_analyzer_readout.sv
// Capture RAM readout: walks addresses 0..total-1 and streams each sample to the host link.
// state | meaning
// IDLE  | waiting for start
// ADDR  | AI presented, RAM read in flight
// LATCH | RAM data valid, loaded into the serializer
// SEND  | bytes handed to the host link
// NEXT  | advance word index or finish
// DONE  | end of dump, AI back to 0, return to idle
module logic_analyzer_readout
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  input  logic              dump_all,
  input  logic [DATA_W-1:0] DATA_OUT_RAM,
  output logic [ADDR_W-1:0] AI,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  la_state_e       state;
  logic [ADDR_W:0] total;
  logic [ADDR_W:0] word_idx;
  logic [ADDR_W:0] word_nxt;
  logic            ser_load;
  logic            last_acc;

  assign word_nxt = word_idx + 1'b1;
  assign ser_load = (state == LATCH);

  la_word_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk          (clk),
    .reset        (reset),
    .load         (ser_load),
    .word_in      (DATA_OUT_RAM),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .last_accepted(last_acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      total    <= '0;
      word_idx <= '0;
      AI       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            word_idx <= '0;
            AI       <= '0;
            total    <= dump_all ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, count};
            state    <= (dump_all || (count != '0)) ? ADDR : DONE;
          end
        end
        ADDR:  state <= LATCH;
        LATCH: state <= SEND;
        SEND: begin
          if (last_acc) state <= NEXT;
        end
        NEXT: begin
          word_idx <= word_nxt;
          if (word_nxt == total) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            AI    <= '0;
            state <= DONE;
          end else begin
            AI    <= word_nxt[ADDR_W-1:0];
            state <= ADDR;
          end
        end
        DONE: begin
          // an empty dump arrives here still busy and pulses done now
          done  <= busy;
          busy  <= 1'b0;
          AI    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_analyzer_readout.sv
// Directed and randomized dumps checked against a byte-stream model of the capture RAM.
module tb_logic_analyzer_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic        dump_all = 1'b0;
  logic [31:0] DATA_OUT_RAM = '0;
  logic [4:0]  AI;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        done;

  logic [31:0] ram [32];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [4:0]  ai_q[$];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int last_hs = 0;
  int hold_err = 0;
  int busy_at_done = 0;
  int valid_seen = 0;
  int ready_mode = 0;
  int pidx = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  logic       pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  logic_analyzer_readout dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .dump_all    (dump_all),
    .DATA_OUT_RAM(DATA_OUT_RAM),
    .AI          (AI),
    .busy        (busy),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .done        (done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read capture RAM
  always @(posedge clk) DATA_OUT_RAM <= ram[AI];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = pat[pidx];
          pidx = (pidx + 1) % 8;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && (tx_valid !== 1'b1 || tx_data !== hold_data)) hold_err++;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_hs = cyc;
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid) valid_seen++;
      if (done) begin
        done_n++;
        done_cyc = cyc;
        if (busy) busy_at_done++;
      end
      if (busy && (ai_q.size() == 0 || ai_q[$] != AI)) ai_q.push_back(AI);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build_exp(input int total);
    exp_q.delete();
    for (int w = 0; w < total; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(ram[w] >> (8 * (3 - b))));
  endfunction

  task automatic check_stream(input string name);
    int n;
    check({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({name, "_hold"}, hold_err, 0);
  endtask

  task automatic clear_mon();
    got_q.delete();
    ai_q.delete();
    done_n = 0;
    hold_err = 0;
    busy_at_done = 0;
    valid_seen = 0;
  endtask

  task automatic run_dump(input int cnt, input bit all, input int extra_start_at);
    clear_mon();
    @(posedge clk);
    #1;
    count = 5'(cnt);
    dump_all = all;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    dump_all = 1'b0;
    count = 5'($urandom);
    for (int i = 0; i < 4000 && done_n == 0; i++) begin
      @(posedge clk);
      #1;
      start = (i == extra_start_at) || (extra_start_at >= 0 && i == extra_start_at + 7);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int total;
    bit seq_ok;

    for (int i = 0; i < 32; i++) ram[i] = $urandom;

    #3;
    check("rst_AI", 32'(AI), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // two-word dump, ready held high
    ram[0] = 32'hDEAD_BEEF;
    ram[1] = 32'h0123_4567;
    ready_mode = 0;
    run_dump(2, 1'b0, -1);
    build_exp(2);
    check_stream("two");
    check("two_ai_len", ai_q.size(), 2);
    if (ai_q.size() == 2) begin
      check("two_ai0", 32'(ai_q[0]), 0);
      check("two_ai1", 32'(ai_q[1]), 1);
    end
    check("two_done_n", done_n, 1);
    check("two_done_lat", done_cyc - last_hs, 2);
    check("two_tput", done_cyc - start_cyc, 7 * 2 + 1);
    check("two_busy_at_done", busy_at_done, 0);
    check("two_busy_after", 32'(busy), 0);

    // empty dump
    run_dump(0, 1'b0, -1);
    check("zero_valid", valid_seen, 0);
    check("zero_len", got_q.size(), 0);
    check("zero_done_n", done_n, 1);
    check("zero_done_lat", done_cyc - start_cyc, 2);
    check("zero_ai_len", ai_q.size(), 1);
    if (ai_q.size() == 1) check("zero_ai", 32'(ai_q[0]), 0);
    check("zero_busy_at_done", busy_at_done, 0);

    // full dump of 32 words
    for (int i = 0; i < 32; i++) ram[i] = {4{8'(i)}};
    run_dump(0, 1'b1, -1);
    build_exp(32);
    check_stream("all");
    if (got_q.size() == 128) begin
      check("all_last0", 32'(got_q[124]), 32'h1F);
      check("all_last3", 32'(got_q[127]), 32'h1F);
    end
    seq_ok = (ai_q.size() == 32);
    for (int i = 0; i < ai_q.size(); i++) if (ai_q[i] != 5'(i)) seq_ok = 1'b0;
    check("all_ai_seq", 32'(seq_ok), 1);
    check("all_done_n", done_n, 1);
    check("all_tput", done_cyc - start_cyc, 7 * 32 + 1);

    // backpressure pattern on a single word
    ram[0] = 32'hA5C3_0F81;
    ready_mode = 1;
    pidx = 0;
    run_dump(1, 1'b0, -1);
    build_exp(1);
    check_stream("bp");
    check("bp_done_n", done_n, 1);
    ready_mode = 0;

    // reset in the middle of a three-word dump
    for (int i = 0; i < 32; i++) ram[i] = $urandom;
    clear_mon();
    @(posedge clk);
    #1;
    count = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200 && got_q.size() < 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_reached5", got_q.size(), 5);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_AI", 32'(AI), 0);
    check("mid_rst_data", 32'(tx_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_done", done_n, 0);
    run_dump(1, 1'b0, -1);
    build_exp(1);
    check_stream("after_rst");
    check("after_rst_done_n", done_n, 1);

    // restart attempts while busy
    run_dump(2, 1'b0, 2);
    build_exp(2);
    check_stream("restart");
    check("restart_done_n", done_n, 1);
    check("restart_ai_len", ai_q.size(), 2);

    // randomized dumps with random backpressure
    for (int k = 0; k < 6; k++) begin
      bit all;
      int cnt;
      for (int i = 0; i < 32; i++) ram[i] = $urandom;
      all = ($urandom_range(0, 3) == 0);
      cnt = $urandom_range(0, 31);
      ready_mode = (k % 2 == 0) ? 2 : 0;
      total = all ? 32 : cnt;
      run_dump(cnt, all, -1);
      build_exp(total);
      check_stream($sformatf("rnd%0d", k));
      check($sformatf("rnd%0d_done_n", k), done_n, 1);
      check($sformatf("rnd%0d_busy_at_done", k), busy_at_done, 0);
      check($sformatf("rnd%0d_ai_len", k), ai_q.size(), (total == 0) ? 1 : total);
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
